// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the multiply/divide controller:
//   - FSM state encoding
//   - mul_con / div_con operation encodings
//   - small arithmetic helpers used for the signed divide fix-up
package muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0] MUL_SIGNED   = 2'b01;
  localparam logic [1:0] MUL_UNSIGNED = 2'b10;
  localparam logic [1:0] DIV_SIGNED   = 2'b01;
  localparam logic [1:0] DIV_UNSIGNED = 2'b10;

  // Number of restoring iterations (one quotient bit each).
  localparam int DIV_STEPS = 32;

  // Two's-complement magnitude; 0x8000_0000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// div_iter
//   Unsigned 32/32 restoring divider, one quotient bit per cycle.
//   A 64-bit shift register holds {remainder, dividend/quotient}; each step
//   shifts one dividend bit into the partial remainder, compares it against
//   the divisor (33-bit) and subtracts when it fits.
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   start               load dividend/divisor and begin 32 iterations
//   abort               cancel an in-flight division (wins over start)
//   dividend, divisor   unsigned operands, sampled on start
//   done                high during the cycle whose clock edge performs the
//                       final iteration; quot/rem are final from the next cycle
//   quot, rem           results, held until the next start
module div_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

  logic [63:0] rq_q, rq_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        run_q, run_d;

  logic [32:0] rem_shift;
  logic        qbit;
  logic [31:0] rem_next;

  always_comb begin
    // Partial remainder with the next dividend bit shifted in.
    rem_shift = rq_q[63:31];
    qbit      = (rem_shift >= {1'b0, dvs_q});
    // When the divisor fits, the true difference is below 2^32, so a
    // 32-bit subtract is exact. Divisor 0 always fits: quotient all ones,
    // remainder equals the dividend.
    rem_next  = qbit ? (rem_shift[31:0] - dvs_q) : rem_shift[31:0];

    rq_d  = rq_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    run_d = run_q;

    if (abort) begin
      run_d = 1'b0;
    end else if (start) begin
      rq_d  = {32'd0, dividend};
      dvs_d = divisor;
      cnt_d = 5'd0;
      run_d = 1'b1;
    end else if (run_q) begin
      rq_d  = {rem_next, rq_q[30:0], qbit};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == LAST_STEP) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rq_q  <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rq_q  <= rq_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done = run_q & (cnt_q == LAST_STEP) & ~abort;
  assign quot = rq_q[31:0];
  assign rem  = rq_q[63:32];

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   Sequences the multi-cycle multiply/divide unit behind EX and owns the
//   architectural HI/LO pair. Multiply uses '*' over MUL_CYCLES cycles so the
//   tools can retime the multiplier; divide is delegated to div_iter with a
//   sign fix-up cycle afterwards.
// Parameters
//   MUL_CYCLES  cycles spent in MUL (>=1)
//   CNT_W       iteration counter width
// Ports
//   clk, reset      clock, asynchronous active-high reset (clears HI/LO)
//   mul_con         01 mult, 10 multu, else none
//   div_con         01 div, 10 divu, else none (mul wins if both valid)
//   src_a, src_b    rs / rt operands
//   hilo_we         {hi_we, lo_we} for mthi/mtlo, hilo_wdata is the data
//   mf_req          mfhi/mflo in EX needs HI/LO this cycle
//   flush           cancels any in-flight operation
//   md_stall        combinational pipeline hold
//   md_busy         registered; FSM is in MUL, DIV or FIX
//   hi, lo          architectural HI/LO
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mul_con,
  input  logic [1:0]  div_con,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [1:0]  hilo_we,
  input  logic [31:0] hilo_wdata,
  input  logic        mf_req,
  input  logic        flush,
  output logic        md_stall,
  output logic        md_busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [32:0]       mul_a_q, mul_a_d;
  logic [32:0]       mul_b_q, mul_b_d;
  logic              qsign_q, qsign_d;
  logic              rsign_q, rsign_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              busy_q, busy_d;

  logic        mul_valid, div_valid, start, start_mul, start_div;
  logic        div_signed, div_start, div_done;
  logic [31:0] div_dividend, div_divisor, div_quot, div_rem;
  logic [63:0] ext_a, ext_b, product;

  assign mul_valid  = (mul_con == MUL_SIGNED) || (mul_con == MUL_UNSIGNED);
  assign div_valid  = (div_con == DIV_SIGNED) || (div_con == DIV_UNSIGNED);
  assign start      = (mul_valid | div_valid) & ~flush;
  assign start_mul  = start & mul_valid;
  assign start_div  = start & ~mul_valid;
  assign div_signed = (div_con == DIV_SIGNED);

  // The divider sees magnitudes; signs are restored in FIX.
  assign div_dividend = div_signed ? abs32(src_a) : src_a;
  assign div_divisor  = div_signed ? abs32(src_b) : src_b;
  assign div_start    = (state_q == ST_IDLE) & start_div;

  // 33-bit operands (sign or zero extended) widened to 64 bits: the low 64
  // bits of this product are the full 33x33 signed product.
  assign ext_a   = {{31{mul_a_q[32]}}, mul_a_q};
  assign ext_b   = {{31{mul_b_q[32]}}, mul_b_q};
  assign product = ext_a * ext_b;

  div_iter u_div_iter (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .abort    (flush),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        // mthi/mtlo lands first; an op accepted this cycle overwrites later.
        if (hilo_we[1]) hi_d = hilo_wdata;
        if (hilo_we[0]) lo_d = hilo_wdata;
        if (start_mul) begin
          mul_a_d = {(mul_con == MUL_SIGNED) & src_a[31], src_a};
          mul_b_d = {(mul_con == MUL_SIGNED) & src_b[31], src_b};
          cnt_d   = MUL_LAST;
          state_d = ST_MUL;
        end else if (start_div) begin
          qsign_d = div_signed & (src_a[31] ^ src_b[31]);
          rsign_d = div_signed & src_a[31];
          state_d = ST_DIV;
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          hi_d    = product[63:32];
          lo_d    = product[31:0];
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (div_done) state_d = ST_FIX;
      end
      ST_FIX: begin
        lo_d    = cond_neg(div_quot, qsign_q);
        hi_d    = cond_neg(div_rem, rsign_q);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // EX still holds the finished instruction, so mul_con/div_con are
        // not looked at here. A write held off while busy lands now.
        if (hilo_we[1]) hi_d = hilo_wdata;
        if (hilo_we[0]) lo_d = hilo_wdata;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush beats everything: no HI/LO update, back to IDLE.
    if (flush) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d == ST_MUL) || (state_d == ST_DIV) || (state_d == ST_FIX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  // Held low during reset even if EX presents a valid op.
  assign md_stall = ~reset & (((state_q == ST_IDLE) & start) |
                              (state_q == ST_MUL) | (state_q == ST_DIV) |
                              (state_q == ST_FIX) |
                              (busy_q & (mf_req | (|hilo_we))));
  assign md_busy  = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl
//   Directed and randomized checks of muldiv_ctrl against an arithmetic
//   reference: expected HI/LO come from plain integer multiply/divide and
//   the architectural corner-case rules, latency from the documented
//   stall-cycle counts.
module tb_muldiv_ctrl;

  localparam int MC = 2;
  localparam int K_MULT = 0, K_MULTU = 1, K_DIV = 2, K_DIVU = 3, K_BOTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mul_con, div_con, hilo_we;
  logic [31:0] src_a, src_b, hilo_wdata;
  logic        mf_req, flush;
  logic        md_stall, md_busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] hi_m, lo_m;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_CYCLES(MC), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .mul_con    (mul_con),
    .div_con    (div_con),
    .src_a      (src_a),
    .src_b      (src_b),
    .hilo_we    (hilo_we),
    .hilo_wdata (hilo_wdata),
    .mf_req     (mf_req),
    .flush      (flush),
    .md_stall   (md_stall),
    .md_busy    (md_busy),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_op(input int kind, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub;
    longint sa, sb;
    int qa, qb;
    case (kind)
      K_MULT, K_BOTH: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      K_MULTU: begin
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
      end
      K_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        // Divide by zero: raw q=all ones, r=|a|, then sign fix-up.
        if (b == 32'd0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        qa = $signed(a);
        qb = $signed(b);
        return {32'(qa % qb), 32'(qa / qb)};
      end
    endcase
  endfunction

  task automatic set_con(input int kind);
    mul_con = 2'b00;
    div_con = 2'b00;
    case (kind)
      K_MULT:  mul_con = 2'b01;
      K_MULTU: mul_con = 2'b10;
      K_DIV:   div_con = 2'b01;
      K_DIVU:  div_con = 2'b10;
      default: begin mul_con = 2'b01; div_con = 2'b01; end
    endcase
  endtask

  // Issue one op, count stall-high cycles, check DONE contents and that the
  // op is not restarted from DONE. mf_at/we_at raise mf_req / hilo_we at
  // that stall cycle (0 = never).
  task automatic run_op(input int kind, input logic [31:0] a, input logic [31:0] b,
                        input int mf_at, input int we_at,
                        input logic [1:0] we, input logic [31:0] wd);
    logic [63:0] exp;
    int n;
    int lat;
    exp = ref_op(kind, a, b);
    lat = (kind == K_DIV || kind == K_DIVU) ? 34 : 1 + MC;
    @(posedge clk); #1;
    src_a = a;
    src_b = b;
    set_con(kind);
    n = 0;
    forever begin
      @(negedge clk);
      if (!md_stall || n > 200) break;
      n++;
      if (n == mf_at) mf_req = 1'b1;
      if (n == we_at) begin hilo_we = we; hilo_wdata = wd; end
    end
    check("stall_cycles", 64'(n), 64'(lat));
    check("busy_in_done", 64'(md_busy), 64'd0);
    check("hi_done", 64'(hi), 64'(exp[63:32]));
    check("lo_done", 64'(lo), 64'(exp[31:0]));
    hi_m = exp[63:32];
    lo_m = exp[31:0];
    if (we_at > 0) begin
      if (we[1]) hi_m = wd;
      if (we[0]) lo_m = wd;
    end
    @(posedge clk); #1;
    mul_con = 2'b00;
    div_con = 2'b00;
    mf_req = 1'b0;
    hilo_we = 2'b00;
    @(negedge clk);
    check("no_restart_stall", 64'(md_stall), 64'd0);
    check("hi_after", 64'(hi), 64'(hi_m));
    check("lo_after", 64'(lo), 64'(lo_m));
    $display("op kind=%0d a=%h b=%h stall=%0d hi=%h lo=%h", kind, a, b, n, hi, lo);
  endtask

  initial begin
    reset = 1'b1;
    mul_con = 2'b00; div_con = 2'b00; hilo_we = 2'b00;
    src_a = '0; src_b = '0; hilo_wdata = '0;
    mf_req = 1'b0; flush = 1'b0;
    hi_m = '0; lo_m = '0;

    // Reset state, with a valid op presented: stall must stay low.
    mul_con = 2'b01;
    repeat (2) @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_stall", 64'(md_stall), 64'd0);
    check("rst_busy", 64'(md_busy), 64'd0);
    mul_con = 2'b00;
    @(posedge clk); #1 reset = 1'b0;

    // Directed arithmetic cases.
    run_op(K_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0, 2'b00, 32'd0);
    run_op(K_DIVU, 32'd100, 32'd7, 0, 0, 2'b00, 32'd0);
    run_op(K_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 2'b00, 32'd0);
    run_op(K_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 2'b00, 32'd0);
    run_op(K_DIVU, 32'd5, 32'd0, 0, 0, 2'b00, 32'd0);
    run_op(K_DIV, 32'hFFFF_FFF7, 32'd0, 0, 0, 2'b00, 32'd0);
    run_op(K_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 2'b00, 32'd0);

    // mf_req during DIV cycle 10 keeps the 34-cycle stall unchanged.
    run_op(K_DIV, 32'd12345, 32'hFFFF_FFF0, 10, 0, 2'b00, 32'd0);

    // mthi in IDLE: hi updates next cycle, lo unchanged.
    @(posedge clk); #1;
    hilo_we = 2'b10; hilo_wdata = 32'hAA;
    @(negedge clk);
    check("mthi_idle_stall", 64'(md_stall), 64'd0);
    @(posedge clk); #1;
    hilo_we = 2'b00;
    hi_m = 32'hAA;
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'(hi_m));
    check("mthi_lo", 64'(lo), 64'(lo_m));
    $display("mthi wdata=000000aa hi=%h lo=%h", hi, lo);

    // mtlo arriving while busy: held off, lands after DONE.
    run_op(K_DIVU, 32'd1000, 32'd3, 0, 5, 2'b01, 32'h1234_5678);

    // Flush at DIV cycle 20.
    @(posedge clk); #1;
    src_a = 32'd999; src_b = 32'd10; set_con(K_DIVU);
    for (int i = 0; i < 20; i++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; mul_con = 2'b00; div_con = 2'b00;
    @(negedge clk);
    check("flush_stall", 64'(md_stall), 64'd0);
    check("flush_busy", 64'(md_busy), 64'd0);
    check("flush_hi", 64'(hi), 64'(hi_m));
    check("flush_lo", 64'(lo), 64'(lo_m));
    $display("flush during divu hi=%h lo=%h", hi, lo);
    run_op(K_DIVU, 32'd77, 32'd5, 0, 0, 2'b00, 32'd0);

    // Asynchronous reset in the middle of MUL.
    @(posedge clk); #1;
    src_a = 32'd9; src_b = 32'd9; set_con(K_MULT);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_stall", 64'(md_stall), 64'd0);
    check("arst_busy", 64'(md_busy), 64'd0);
    $display("async reset mid-mult hi=%h lo=%h", hi, lo);
    mul_con = 2'b00;
    hi_m = '0; lo_m = '0;
    @(posedge clk); #1 reset = 1'b0;

    // Both con fields valid: multiply wins.
    run_op(K_BOTH, 32'hFFFF_FFF0, 32'd3, 0, 0, 2'b00, 32'd0);

    // Randomized ops with a bias toward corner operands.
    for (int i = 0; i < 24; i++) begin
      int kind;
      int sel;
      logic [31:0] ra, rb;
      kind = $urandom_range(0, 3);
      sel = $urandom_range(0, 7);
      ra = $urandom;
      rb = $urandom;
      case (sel)
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 100);
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = 32'hFFFF_FFFF - $urandom_range(0, 20);
        default: ;
      endcase
      run_op(kind, ra, rb, 0, 0, 2'b00, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
